mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for the 32-bit MIPS datapath. It sits directly downstream of RegisterFile in the execute stage.
- Consumes ReadData1/ReadData2 as OperandA/OperandB and holds the HI/LO architectural registers.
- Executes MULT, MULTU, DIV, DIVU (multi-cycle) and MTHI, MTLO (single-cycle).
- MFHI/MFLO are served combinationally by the control path reading the Hi/Lo outputs.

Parameters:
- WIDTH, 32, operand and HI/LO width. The iteration count equals WIDTH.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- Start  in  1  request strobe; sampled only when Busy=0.
- Op  in  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved (no-op).
- OperandA  in  WIDTH  rs value (ReadData1): multiplicand / dividend / MTHI-MTLO source.
- OperandB  in  WIDTH  rt value (ReadData2): multiplier / divisor.
- Busy  out  1  high while a multi-cycle operation is in flight.
- Done  out  1  one-cycle pulse when Hi/Lo receive a multi-cycle result.
- DivByZero  out  1  pulses with Done when a DIV/DIVU divisor was 0.
- Hi  out  WIDTH  HI register.
- Lo  out  WIDTH  LO register.

Behaviour:
- Clock and reset: single clock Clk; synchronous active-low reset Reset_n.
- Reset: Hi=0, Lo=0, Busy=0, Done=0, DivByZero=0, state=IDLE, counter=0.
  - Reset asserted mid-operation aborts it. No partial result is written.
- States: IDLE, PREP, ITER, FIX.
- IDLE + Start + MULT/MULTU/DIV/DIVU at edge N:
  - Latch operands and Op.
  - Busy=1 from edge N; state goes to PREP.
- PREP (edge N+1):
  - Signed ops: take absolute values and record result signs.
  - Record divisor==0 flag; clear accumulator; counter=0.
  - Go to ITER.
- ITER (edges N+2..N+33), one iteration per cycle, WIDTH iterations:
  - Multiply: radix-2 shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract.
  - Go to FIX when counter reaches WIDTH-1.
- FIX (edge N+34):
  - Apply sign correction and write Hi/Lo.
  - Done=1 and Busy=0 for exactly one cycle; return to IDLE.
  - Total latency from accepting edge to result edge: 34 cycles.
- Multiply result: Hi = upper WIDTH bits of the 2*WIDTH-bit product, Lo = lower WIDTH bits.
  - MULT is signed two's complement; MULTU is unsigned.
- Divide result: Lo = quotient, Hi = remainder.
  - Signed quotient truncates toward zero; remainder sign follows the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0 (wraps, no flag).
- Divisor 0, signed or unsigned:
  - Latency unchanged.
  - Lo=0xFFFFFFFF, Hi=original OperandA; DivByZero pulses with Done.
- MTHI/MTLO in IDLE + Start at edge N:
  - Hi (or Lo) takes OperandA at edge N.
  - Busy stays 0; Done is not asserted.
- Start while Busy=1: ignored. Latched operands and Op stay stable.
- Reserved Op: ignored; no state change.
- Hi/Lo change only on a FIX edge, an MTHI/MTLO edge, or reset.
- Back-to-back requests: Start at the edge where Done=1 (Busy=0, state IDLE) is accepted. Minimum spacing is 35 cycles.

Decomposition:
- Shared package mips_pkg holds:
  - MD_OP_* encodings and the md_state_t enum (IDLE/PREP/ITER/FIX).
  - WORD_W=32.
- One sub-module, md_sign_fix (combinational):
  - Computes absolute values of operands in PREP.
  - Negates product, quotient and remainder in FIX.
  - Reused for both operand and result correction.
- Iteration datapath and FSM stay in mult_div_unit.

Test Plan:
- MULT A=0x00000007, B=0xFFFFFFFD -> after 34 cycles Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; Done pulses once; Busy high for exactly 34 cycles.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
- DIV A=0xFFFFFFF9 (-7), B=0x00000002 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1). Then DIVU A=100, B=7 -> Lo=14, Hi=2.
- DIVU A=0x00000064, B=0 -> Lo=0xFFFFFFFF, Hi=0x00000064; DivByZero and Done pulse together.
- MULT started, then Start+MTHI (A=0x1234) at cycle 5 -> ignored; Hi equals the product at the Done edge, not 0x1234. Then MTLO A=0xABCD in IDLE -> Lo=0xABCD next edge, Busy stays 0.
- Start DIV, drive Reset_n=0 at cycle 10 -> next edge Busy=0, Hi=Lo=0, no Done. New MULTU 3*5 after release -> Lo=15, Hi=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS execute-stage multiply/divide unit:
// operation encodings, FSM state type and the datapath word width.
package mips_pkg;

  localparam int WORD_W = 32;

  localparam logic [2:0] MD_OP_MULT  = 3'b000;
  localparam logic [2:0] MD_OP_MULTU = 3'b001;
  localparam logic [2:0] MD_OP_DIV   = 3'b010;
  localparam logic [2:0] MD_OP_DIVU  = 3'b011;
  localparam logic [2:0] MD_OP_MTHI  = 3'b100;
  localparam logic [2:0] MD_OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } md_state_t;

  // MULT/MULTU/DIV/DIVU all have a clear top opcode bit.
  function automatic logic md_is_multicycle(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negation of a double word, either as one
// 2*W value (product) or as two independent W halves (operands, rem/quot).
module md_sign_fix
  import mips_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic [2*W-1:0] val_i,
  input  logic           wide_i,
  input  logic           neg_hi_i,
  input  logic           neg_lo_i,
  output logic [2*W-1:0] res_o
);

  logic [W-1:0] hi_in;
  logic [W-1:0] lo_in;
  logic [W-1:0] hi_out;
  logic [W-1:0] lo_out;

  assign hi_in  = val_i[2*W-1:W];
  assign lo_in  = val_i[W-1:0];
  assign hi_out = neg_hi_i ? (~hi_in + W'(1)) : hi_in;
  assign lo_out = neg_lo_i ? (~lo_in + W'(1)) : lo_in;

  always_comb begin
    if (wide_i) begin
      res_o = neg_hi_i ? (~val_i + (2*W)'(1)) : val_i;
    end else begin
      res_o = {hi_out, lo_out};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers.
// Sign-magnitude around an unsigned shift-add / restoring-divide core.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  md_state_t          state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_hi_q, neg_hi_d, neg_lo_q, neg_lo_d;
  logic               dz_q, dz_d, done_q, done_d, dbz_q, dbz_d;

  logic               is_div, is_signed;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] fix_val, fix_res;
  logic               fix_wide, fix_neg_hi, fix_neg_lo;

  assign is_div    = (op_q == MD_OP_DIV) || (op_q == MD_OP_DIVU);
  assign is_signed = (op_q == MD_OP_MULT) || (op_q == MD_OP_DIV);

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, b_q});
  assign div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, b_q}) : div_shift[WIDTH-1:0];

  // One sign fixer: operand magnitudes in PREP, result correction in FIX.
  always_comb begin
    if (state_q == PREP) begin
      fix_val    = {a_q, b_q};
      fix_wide   = 1'b0;
      fix_neg_hi = is_signed & a_q[WIDTH-1];
      fix_neg_lo = is_signed & b_q[WIDTH-1];
    end else begin
      fix_val    = acc_q;
      fix_wide   = !is_div;
      fix_neg_hi = neg_hi_q;
      fix_neg_lo = neg_lo_q;
    end
  end

  md_sign_fix #(.W(WIDTH)) u_sign_fix (
    .val_i    (fix_val),
    .wide_i   (fix_wide),
    .neg_hi_i (fix_neg_hi),
    .neg_lo_i (fix_neg_lo),
    .res_o    (fix_res)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start && md_is_multicycle(Op)) state_d = PREP;
      PREP:    state_d = ITER;
      ITER:    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign Busy      = (state_q != IDLE);
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign Hi        = hi_q;
  assign Lo        = lo_q;

  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_hi_d = neg_hi_q;
    neg_lo_d = neg_lo_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          if (md_is_multicycle(Op)) begin
            op_d = Op;
            a_d  = OperandA;
            b_d  = OperandB;
          end else if (Op == MD_OP_MTHI) begin
            hi_d = OperandA;
          end else if (Op == MD_OP_MTLO) begin
            lo_d = OperandA;
          end
        end
      end
      PREP: begin
        // a_q keeps the raw dividend for the divide-by-zero result.
        acc_d    = {{WIDTH{1'b0}}, fix_res[2*WIDTH-1:WIDTH]};
        b_d      = fix_res[WIDTH-1:0];
        neg_lo_d = is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        neg_hi_d = is_div ? (is_signed & a_q[WIDTH-1]) : (is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]));
        dz_d     = is_div && (b_q == '0);
        cnt_d    = '0;
      end
      ITER: begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = is_div ? {div_rem, acc_q[WIDTH-2:0], div_ge} : {mul_sum, acc_q[WIDTH-1:1]};
      end
      FIX: begin
        done_d = 1'b1;
        dbz_d  = dz_q;
        if (dz_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = fix_res[2*WIDTH-1:WIDTH];
          lo_d = fix_res[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_hi_q <= 1'b0;
      neg_lo_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_hi_q <= neg_hi_d;
      neg_lo_q <= neg_lo_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

endmodule
